// File: rtl/core_regfile_mp.sv
// Purpose : CPU core register file: GP registers, PC, constants, latched bus input.
// Latency : reads are combinational (0 cycles); writes/PC/BUS update on the next rising edge.
// Backpressure: BUS uses a bus_valid/bus_consume handshake; stall flags a read of an empty BUS.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   addr_a/data_a          read port A (combinational)
//   addr_b/data_b          read port B (combinational)
//   addr_w/data_w/we       write port, applied at the rising edge
//   pc_inc/pc_branch       PC advance by 1 / by signed pc_offset
//   pc_default             PC value loaded during reset
//   pc_out                 current PC
//   bus_datain/bus_fromin  bus capture into the BUS register
//   bus_consume            consumer accepts the BUS value this cycle
//   bus_valid/stall        BUS occupancy; read-of-empty-BUS indication
//   mon_out                debug view of gp[MON_IDX]
module core_regfile_mp #(
  parameter int DATA_W  = 16,
  parameter int NUM_GP  = 11,
  parameter int ADDR_W  = $clog2(NUM_GP + 5),
  parameter int BYPASS  = 1,
  parameter int MON_IDX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic              we,
  input  logic              pc_inc,
  input  logic              pc_branch,
  input  logic [DATA_W-1:0] pc_offset,
  input  logic [DATA_W-1:0] pc_default,
  output logic [DATA_W-1:0] pc_out,
  input  logic [DATA_W-1:0] bus_datain,
  input  logic              bus_fromin,
  input  logic              bus_consume,
  output logic              bus_valid,
  output logic              stall,
  output logic [DATA_W-1:0] mon_out
);

  // Address map. Everything above the GP range is a fixed slot.
  localparam logic [ADDR_W-1:0] A_PC   = ADDR_W'(NUM_GP);
  localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(NUM_GP + 1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(NUM_GP + 2);
  localparam logic [ADDR_W-1:0] A_ONES = ADDR_W'(NUM_GP + 3);
  localparam logic [ADDR_W-1:0] A_BUS  = ADDR_W'(NUM_GP + 4);

  logic [DATA_W-1:0] gp [NUM_GP];
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] bus_reg;
  logic              bus_vld;

  logic wr_gp;
  logic wr_pc;

  assign wr_gp = we && (addr_w < A_PC);
  assign wr_pc = we && (addr_w == A_PC);

  // ------------------------------------------------------------------
  // General-purpose registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GP; i++) begin
        gp[i] <= '0;
      end
    end else if (wr_gp) begin
      gp[addr_w] <= data_w;
    end
  end

  // ------------------------------------------------------------------
  // Program counter. An explicit write beats branch, branch beats
  // increment; arithmetic wraps at DATA_W bits.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= pc_default;
    end else if (wr_pc) begin
      pc <= data_w;
    end else if (pc_branch) begin
      pc <= pc + pc_offset;
    end else if (pc_inc) begin
      pc <= pc + DATA_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // BUS input register. A capture always wins over a consume, so a
  // simultaneous capture/consume leaves fresh data valid.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_reg <= '0;
      bus_vld <= 1'b0;
    end else if (bus_fromin) begin
      bus_reg <= bus_datain;
      bus_vld <= 1'b1;
    end else if (bus_consume) begin
      bus_vld <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Read ports. Both ports share one decoder body instantiated twice.
  // Only GP and PC slots are forwardable; constants and BUS always read
  // their own value. PC arithmetic updates are never forwarded.
  // ------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = addr_a;
  assign rd_addr[1] = addr_b;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic fwd;

    assign fwd = (BYPASS != 0) && we && (rd_addr[p] == addr_w) && (rd_addr[p] <= A_PC);

    always_comb begin
      rd_data[p] = '0;
      if (fwd) begin
        rd_data[p] = data_w;
      end else if (rd_addr[p] < A_PC) begin
        rd_data[p] = gp[rd_addr[p]];
      end else if (rd_addr[p] == A_PC) begin
        rd_data[p] = pc;
      end else if (rd_addr[p] == A_ZERO) begin
        rd_data[p] = '0;
      end else if (rd_addr[p] == A_ONE) begin
        rd_data[p] = DATA_W'(1);
      end else if (rd_addr[p] == A_ONES) begin
        rd_data[p] = '1;
      end else if (rd_addr[p] == A_BUS) begin
        // Stale contents are returned while empty; stall tells the reader.
        rd_data[p] = bus_reg;
      end
    end
  end

  assign data_a    = rd_data[0];
  assign data_b    = rd_data[1];
  assign pc_out    = pc;
  assign bus_valid = bus_vld;
  assign stall     = ((addr_a == A_BUS) || (addr_b == A_BUS)) && !bus_vld;
  assign mon_out   = gp[MON_IDX];

endmodule

// File: tb/tb_core_regfile_mp.sv
module tb_core_regfile_mp;

  localparam int NGP = 11;

  logic        clk;
  logic        rst;
  logic [3:0]  addr_a, addr_b, addr_w;
  logic [15:0] data_w, pc_offset, pc_default, bus_datain;
  logic        we, pc_inc, pc_branch, bus_fromin, bus_consume;

  // BYPASS=1 instance outputs
  logic [15:0] da1, db1, pc1, mon1;
  logic        bv1, st1;
  // BYPASS=0 instance outputs
  logic [15:0] da0, db0, pc0, mon0;
  logic        bv0, st0;

  int n_cmp = 0;
  int n_bad = 0;

  core_regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b), .data_a(da1), .data_b(db1),
    .addr_w(addr_w), .data_w(data_w), .we(we), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .pc_offset(pc_offset), .pc_default(pc_default), .pc_out(pc1), .bus_datain(bus_datain),
    .bus_fromin(bus_fromin), .bus_consume(bus_consume), .bus_valid(bv1), .stall(st1),
    .mon_out(mon1)
  );

  core_regfile_mp #(.BYPASS(0)) u_nbyp (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b), .data_a(da0), .data_b(db0),
    .addr_w(addr_w), .data_w(data_w), .we(we), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .pc_offset(pc_offset), .pc_default(pc_default), .pc_out(pc0), .bus_datain(bus_datain),
    .bus_fromin(bus_fromin), .bus_consume(bus_consume), .bus_valid(bv0), .stall(st0),
    .mon_out(mon0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (spec rules, integer arithmetic) ----
  logic [15:0] m_gp [NGP];
  int          m_pc;
  logic [15:0] m_bus;
  bit          m_bv;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NGP; i++) m_gp[i] <= 16'h0;
      m_pc  <= int'(pc_default);
      m_bus <= 16'h0;
      m_bv  <= 1'b0;
    end else begin
      if (we && int'(addr_w) < NGP) m_gp[addr_w] <= data_w;
      if (we && int'(addr_w) == NGP)  m_pc <= int'(data_w);
      else if (pc_branch)             m_pc <= (m_pc + int'(pc_offset)) % 65536;
      else if (pc_inc)                m_pc <= (m_pc + 1) % 65536;
      if (bus_fromin) begin
        m_bus <= bus_datain;
        m_bv  <= 1'b1;
      end else if (bus_consume) begin
        m_bv  <= 1'b0;
      end
    end
  end

  function automatic logic [15:0] ref_read(input int a, input bit byp);
    logic [15:0] r;
    r = 16'h0;
    if (byp && we && a == int'(addr_w) && a <= NGP) r = data_w;
    else if (a < NGP)       r = m_gp[a];
    else if (a == NGP)      r = 16'(m_pc);
    else if (a == NGP + 2)  r = 16'h0001;
    else if (a == NGP + 3)  r = 16'hFFFF;
    else if (a == NGP + 4)  r = m_bus;
    return r;
  endfunction

  // ---------------- helpers ---------------------------------------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rst = 0; we = 0; pc_inc = 0; pc_branch = 0; bus_fromin = 0; bus_consume = 0;
    addr_a = 0; addr_b = 0; addr_w = 0; data_w = 0; pc_offset = 0; bus_datain = 0;
  endtask

  // Expected post-reset read value with pc_default = 0x0100.
  function automatic logic [15:0] exp_rst(input int a);
    if (a < NGP)          return 16'h0000;
    else if (a == NGP)    return 16'h0100;
    else if (a == NGP + 2) return 16'h0001;
    else if (a == NGP + 3) return 16'hFFFF;
    else                  return 16'h0000;
  endfunction

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        es;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // ---------------- reset -------------------------------------------
    idle();
    pc_default = 16'h0100;
    rst = 1;
    tick();
    tick();
    rst = 0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].a  = 4'(i);
      tbl[i].b  = 4'(15 - i);
      tbl[i].ea = exp_rst(i);
      tbl[i].eb = exp_rst(15 - i);
      tbl[i].es = (i == 15) || (i == 0);
    end

    #3;
    chk("rst_pc", pc1, 16'h0100);
    chk("rst_mon", mon1, 16'h0000);
    chk("rst_bv", {15'h0, bv1}, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      addr_a = tbl[i].a;
      addr_b = tbl[i].b;
      #1;
      chk($sformatf("rst_rd_a[%0d]", i), da1, tbl[i].ea);
      chk($sformatf("rst_rd_b[%0d]", i), db1, tbl[i].eb);
      chk($sformatf("rst_rd_a_nb[%0d]", i), da0, tbl[i].ea);
      chk($sformatf("rst_rd_b_nb[%0d]", i), db0, tbl[i].eb);
      chk($sformatf("rst_stall[%0d]", i), {15'h0, st1}, {15'h0, tbl[i].es});
    end
    tick();

    // ---------------- write bypass ------------------------------------
    addr_a = 3; we = 1; addr_w = 3; data_w = 16'hBEEF;
    #3;
    chk("byp_same", da1, 16'hBEEF);
    chk("nbyp_same", da0, 16'h0000);
    tick();
    we = 0;
    #3;
    chk("byp_next", da1, 16'hBEEF);
    chk("nbyp_next", da0, 16'hBEEF);
    addr_a = 13; we = 1; addr_w = 13; data_w = 16'h1234;
    #1;
    chk("const_nobyp", da1, 16'h0001);
    tick();
    we = 0;
    #3;
    chk("const_after", da1, 16'h0001);

    // ---------------- PC ----------------------------------------------
    we = 1; addr_w = 11; data_w = 16'hFFFF;
    tick();
    we = 0; pc_inc = 1; addr_a = 11;
    #3;
    chk("pc_ld", pc1, 16'hFFFF);
    chk("pc_rd_pre_inc", da1, 16'hFFFF);
    tick();
    pc_inc = 0;
    #3;
    chk("pc_wrap", pc1, 16'h0000);
    we = 1; addr_w = 11; data_w = 16'h0010;
    tick();
    we = 0; pc_branch = 1; pc_offset = 16'hFFFC;
    tick();
    pc_branch = 0;
    #3;
    chk("pc_branch_neg", pc1, 16'h000C);
    we = 1; addr_w = 11; data_w = 16'h0400; pc_inc = 1; pc_branch = 1; pc_offset = 16'h0100;
    #1;
    chk("pc_wr_byp", da1, 16'h0400);
    chk("pc_wr_nbyp", da0, 16'h000C);
    tick();
    idle();
    #3;
    chk("pc_wr_prio", pc1, 16'h0400);
    chk("pc_wr_prio_nb", pc0, 16'h0400);

    // ---------------- BUS handshake -----------------------------------
    addr_a = 15;
    #1;
    chk("bus_stall0", {15'h0, st1}, 16'h0001);
    bus_fromin = 1; bus_datain = 16'hA5A5;
    tick();
    bus_fromin = 0;
    #3;
    chk("bus_bv1", {15'h0, bv1}, 16'h0001);
    chk("bus_stall1", {15'h0, st1}, 16'h0000);
    chk("bus_data1", da1, 16'hA5A5);
    bus_consume = 1;
    tick();
    bus_consume = 0;
    #3;
    chk("bus_bv_cons", {15'h0, bv1}, 16'h0000);
    chk("bus_stall_cons", {15'h0, st1}, 16'h0001);
    chk("bus_stale", da1, 16'hA5A5);
    bus_fromin = 1; bus_consume = 1; bus_datain = 16'h5A5A;
    tick();
    #3;
    chk("bus_both_bv", {15'h0, bv1}, 16'h0001);
    chk("bus_both_data", da1, 16'h5A5A);
    bus_datain = 16'h1357;  // capture+consume again while already valid
    tick();
    bus_fromin = 0; bus_consume = 0;
    #3;
    chk("bus_both_bv2", {15'h0, bv1}, 16'h0001);
    chk("bus_both_data2", da1, 16'h1357);

    // ---------------- reset overrides ---------------------------------
    we = 1; addr_w = 7; data_w = 16'h7777;
    tick();
    we = 0;
    #3;
    chk("mon_pre_rst", mon1, 16'h7777);
    rst = 1; we = 1; addr_w = 7; data_w = 16'h1111; pc_branch = 1; pc_offset = 16'h0005;
    bus_fromin = 1; bus_datain = 16'h9999;
    tick();
    idle();
    addr_a = 15;
    #3;
    chk("rst_ovr_mon", mon1, 16'h0000);
    chk("rst_ovr_pc", pc1, 16'h0100);
    chk("rst_ovr_bv", {15'h0, bv1}, 16'h0000);
    chk("rst_ovr_bus", da1, 16'h0000);
    chk("rst_ovr_stall", {15'h0, st1}, 16'h0001);

    // ---------------- randomized vs model -----------------------------
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 39) == 0);
      if (rst) pc_default = 16'($urandom);
      addr_a      = 4'($urandom);
      addr_b      = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom);
      we          = $urandom_range(0, 1) == 1;
      addr_w      = ($urandom_range(0, 2) == 0) ? addr_a : 4'($urandom);
      data_w      = 16'($urandom);
      pc_inc      = $urandom_range(0, 1) == 1;
      pc_branch   = $urandom_range(0, 3) == 0;
      pc_offset   = 16'($urandom);
      bus_fromin  = $urandom_range(0, 3) == 0;
      bus_consume = $urandom_range(0, 2) == 0;
      bus_datain  = 16'($urandom);
      #3;
      chk("rnd_da_byp",  da1, ref_read(int'(addr_a), 1'b1));
      chk("rnd_db_byp",  db1, ref_read(int'(addr_b), 1'b1));
      chk("rnd_da_nbyp", da0, ref_read(int'(addr_a), 1'b0));
      chk("rnd_db_nbyp", db0, ref_read(int'(addr_b), 1'b0));
      chk("rnd_pc",      pc1, 16'(m_pc));
      chk("rnd_pc_nb",   pc0, 16'(m_pc));
      chk("rnd_mon",     mon1, m_gp[7]);
      chk("rnd_bv",      {15'h0, bv1}, {15'h0, m_bv});
      chk("rnd_stall",   {15'h0, st1},
          {15'h0, ((addr_a == 4'd15) || (addr_b == 4'd15)) && !m_bv});
      chk("rnd_stall_nb", {15'h0, st0}, {15'h0, st1});
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_regfile_mp.md
Name: core_regfile_mp

Overview:
- Parametrised successor to the core register file.
- Provides NUM_GP general-purpose registers, a program counter with increment and relative-branch support, and three constant pseudo-registers.
- Adds two independent combinational read ports, optional write-to-read bypass, and a latched bus-input register with valid/stall handshake.
- Sits between decode/execute and the memory bus interface in the CPU core.

Parameters:
- DATA_W, 16, datapath width of all registers and ports.
- NUM_GP, 11, number of general-purpose registers (>=1).
- ADDR_W, $clog2(NUM_GP+5), register address width.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return pre-write contents.
- MON_IDX, 7, index of the GP register driven on mon_out (< NUM_GP).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- addr_a  in  ADDR_W  read port A address.
- addr_b  in  ADDR_W  read port B address.
- data_a  out  DATA_W  read port A data (combinational).
- data_b  out  DATA_W  read port B data (combinational).
- addr_w  in  ADDR_W  write address.
- data_w  in  DATA_W  write data.
- we  in  1  write enable.
- pc_inc  in  1  advance PC by 1.
- pc_branch  in  1  add pc_offset to PC.
- pc_offset  in  DATA_W  signed two's-complement branch offset.
- pc_default  in  DATA_W  PC value loaded at reset.
- pc_out  out  DATA_W  current PC.
- bus_datain  in  DATA_W  bus input data.
- bus_fromin  in  1  capture bus_datain into BUS register.
- bus_consume  in  1  consumer accepts BUS value this cycle.
- bus_valid  out  1  BUS register holds unconsumed data.
- stall  out  1  a read port addresses BUS while bus_valid=0.
- mon_out  out  DATA_W  gp[MON_IDX].

Behaviour:
- Address map:
  - 0..NUM_GP-1 = GP.
  - NUM_GP = PC.
  - NUM_GP+1 = constant 0.
  - NUM_GP+2 = constant 1 (zero-extended).
  - NUM_GP+3 = all ones.
  - NUM_GP+4 = BUS.
  - Addresses > NUM_GP+4 read 0.
- Reads are purely combinational, zero latency, both ports independent; the same address on both ports is legal.
- Writes take effect at the rising edge when we=1:
  - To a GP address: updates that GP register.
  - To PC: loads PC.
  - To constant, BUS or out-of-range addresses: ignored.
- Bypass:
  - BYPASS=1: a read address equal to addr_w with we=1 and addr_w a GP/PC address returns data_w in the same cycle.
  - Constants are never bypassed.
- PC update priority (highest first):
  - rst: PC <= pc_default.
  - we with addr_w=PC: PC <= data_w.
  - pc_branch: PC <= PC + pc_offset.
  - pc_inc: PC <= PC + 1.
  - Otherwise hold.
  - All PC arithmetic is modulo 2^DATA_W (wraps silently).
  - A PC read during pc_inc/pc_branch returns the pre-update value (no bypass for arithmetic updates).
- BUS handshake:
  - bus_fromin=1: bus_reg <= bus_datain and bus_valid <= 1 next cycle.
  - bus_consume=1 with bus_valid=1: bus_valid <= 0.
  - Simultaneous bus_fromin and bus_consume: new data captured, bus_valid stays 1.
  - bus_fromin while already valid: overwrites (no overflow flag).
  - bus_consume with bus_valid=0: ignored.
  - stall = (addr_a==BUS or addr_b==BUS) and !bus_valid; combinational.
  - Reading BUS with bus_valid=0 returns the stale bus_reg.
- Reset (any cycle, including mid-branch or mid-handshake):
  - All GP <= 0; PC <= pc_default; bus_reg <= 0; bus_valid <= 0.
  - rst overrides we, pc_inc, pc_branch and bus_fromin in that cycle.
- Reset values of outputs on the cycle after reset:
  - pc_out = pc_default; mon_out = 0; bus_valid = 0.
  - data_a and data_b are per the address map, with GP and BUS reads returning 0.
  - stall follows the addresses (1 if either port addresses BUS).

Test Plan:
- Reset with pc_default=16'h0100, then read all addresses on both ports:
  - GP=0, PC=0x0100.
  - NUM_GP+1=0, NUM_GP+2=1, NUM_GP+3=0xFFFF.
  - 15 (BUS) = 0 with stall=1.
- Write 0xBEEF to GP3 with addr_a=3 in the same cycle:
  - BYPASS=1: data_a=0xBEEF that cycle.
  - BYPASS=0: data_a=0 that cycle, 0xBEEF the next.
  - Write 0x1234 to address 13 (constant 1): data_a=1 afterwards.
- PC=0xFFFF with pc_inc -> PC=0x0000.
- PC=0x0010 with pc_branch, pc_offset=0xFFFC -> PC=0x000C.
- Same cycle we to PC with data_w=0x0400, pc_inc=1, pc_branch=1 -> PC=0x0400.
- BUS handshake with addr_a=15:
  - Before capture: stall=1.
  - bus_fromin with 0xA5A5 -> next cycle bus_valid=1, stall=0, data_a=0xA5A5.
  - bus_consume -> bus_valid=0, stall=1.
  - Simultaneous bus_fromin (0x5A5A) and bus_consume -> bus_valid stays 1, data_a=0x5A5A.
- Write 0x7777 to GP7, then assert rst concurrently with we to GP7 (0x1111), pc_branch and bus_fromin:
  - Before reset: mon_out=0x7777.
  - After reset: mon_out=0, PC=pc_default, bus_valid=0.
